// File: rtl/adc_dec_formatter.sv
// ADC sample to ASCII decimal line formatter for a byte-wide UART.
// Emits "+ddddd\r\n" per sample and "E\r\n" once per driver error episode.
module adc_dec_formatter #(
    parameter int SIGNED = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_error,
    output logic        o_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    input  logic        i_tx_busy,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND,
        ERR
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [15:0] mag_q;
    logic [19:0] bcd_q;
    logic [3:0]  bit_cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  sign_q;
    logic        start_q;
    logic [7:0]  tx_data_q;
    logic [7:0]  drop_q;
    logic        err_sent_q;

    logic        is_neg;
    logic [15:0] mag_in;
    logic        err_go;
    logic        tx_go;
    logic        last_byte;
    logic [15:0] bcd_adj;
    logic [7:0]  byte_sel;

    always_comb begin
        is_neg    = (SIGNED != 0) && i_data[15];
        mag_in    = is_neg ? (~i_data + 16'd1) : i_data;
        err_go    = i_error && !err_sent_q;
        tx_go     = ((state_q == SEND) || (state_q == ERR))
                    && !i_tx_busy && !start_q;
        last_byte = (state_q == SEND) ? (idx_q == 3'd7)
                                      : (idx_q == 3'd2);
    end

    // Top digit never exceeds 6, so it never needs the add-3 step.
    always_comb begin
        bcd_adj = bcd_q[15:0];
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        byte_sel = 8'h0A;
        if (state_q == SEND) begin
            case (idx_q)
                3'd0:    byte_sel = sign_q;
                3'd1:    byte_sel = {4'h3, bcd_q[19:16]};
                3'd2:    byte_sel = {4'h3, bcd_q[15:12]};
                3'd3:    byte_sel = {4'h3, bcd_q[11:8]};
                3'd4:    byte_sel = {4'h3, bcd_q[7:4]};
                3'd5:    byte_sel = {4'h3, bcd_q[3:0]};
                3'd6:    byte_sel = 8'h0D;
                default: byte_sel = 8'h0A;
            endcase
        end else begin
            case (idx_q)
                3'd0:    byte_sel = 8'h45;
                3'd1:    byte_sel = 8'h0D;
                default: byte_sel = 8'h0A;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (err_go) begin
                    state_d = ERR;
                end else if (i_valid) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (bit_cnt_q == 4'd15) begin
                    state_d = SEND;
                end
            end
            SEND, ERR: begin
                if (tx_go && last_byte) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state_q == IDLE) && i_rst_n;
        o_tx_start = start_q;
        o_tx_data  = tx_data_q;
        o_drop_cnt = drop_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mag_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            sign_q     <= '0;
            start_q    <= 1'b0;
            tx_data_q  <= '0;
            drop_q     <= '0;
            err_sent_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (err_go) begin
                        idx_q <= '0;
                    end else if (i_valid) begin
                        mag_q     <= mag_in;
                        bcd_q     <= '0;
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                        sign_q    <= is_neg ? 8'h2D : 8'h2B;
                    end
                end
                CONV: begin
                    bcd_q     <= {bcd_q[18:16], bcd_adj, mag_q[15]};
                    mag_q     <= {mag_q[14:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                SEND, ERR: begin
                    if (tx_go) begin
                        start_q   <= 1'b1;
                        tx_data_q <= byte_sel;
                        idx_q     <= idx_q + 3'd1;
                    end
                end
                default: ;
            endcase

            if (i_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            if (!i_error) begin
                err_sent_q <= 1'b0;
            end else if ((state_q == ERR) && tx_go && last_byte) begin
                err_sent_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_dec_formatter.sv
// Directed bench for adc_dec_formatter: signed and unsigned instances
// share stimulus; a UART model captures bytes and emulates busy.
module tb_adc_dec_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic        valid;
    logic        error;
    logic        busy;

    logic        ready_s, start_s, ready_u, start_u;
    logic [7:0]  txd_s, drop_s, txd_u, drop_u;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    logic [7:0] q_s[$];
    logic [7:0] q_u[$];

    always #5 clk = ~clk;

    adc_dec_formatter #(.SIGNED(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .i_error(error), .o_ready(ready_s), .o_tx_data(txd_s),
        .o_tx_start(start_s), .i_tx_busy(busy), .o_drop_cnt(drop_s)
    );

    adc_dec_formatter #(.SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .i_error(error), .o_ready(ready_u), .o_tx_data(txd_u),
        .o_tx_start(start_u), .i_tx_busy(busy), .o_drop_cnt(drop_u)
    );

    // UART model: capture bytes, hold busy for busy_len cycles per byte
    always @(negedge clk) begin
        if (start_s) begin
            if (busy) viol++;
            q_s.push_back(txd_s);
        end
        if (start_u) q_u.push_back(txd_u);
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) busy = 1'b0;
        end else if (start_s && busy_len > 0) begin
            busy = 1'b1;
            busy_cnt = busy_len;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] pop_line(input bit u, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (u) begin
                if (q_u.size() > 0) r = {r[55:0], q_u.pop_front()};
            end else begin
                if (q_s.size() > 0) r = {r[55:0], q_s.pop_front()};
            end
        end
        return r;
    endfunction

    task automatic send_sample(input logic [15:0] d);
        int k = 0;
        while (!ready_s && k < 20000) begin
            step();
            k++;
        end
        total++;
        if (ready_s !== 1'b1) begin
            bad++;
            $display("FAIL send_ready got=%b exp=1", ready_s);
        end
        data = d;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (q_s.size() < n && k < budget) begin
            step();
            k++;
        end
        total++;
        if (q_s.size() < n) begin
            bad++;
            $display("FAIL byte_timeout got=%0d exp=%0d", q_s.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        error = 1'b0;
        busy = 1'b0;
        data = '0;
        repeat (3) step();
        total++;
        if (ready_s !== 1'b0) begin
            bad++; $display("FAIL rst_ready got=%b exp=0", ready_s);
        end
        total++;
        if (start_s !== 1'b0) begin
            bad++; $display("FAIL rst_start got=%b exp=0", start_s);
        end
        total++;
        if (txd_s !== 8'h00) begin
            bad++; $display("FAIL rst_txdata got=%h exp=00", txd_s);
        end
        total++;
        if (drop_s !== 8'h00) begin
            bad++; $display("FAIL rst_drop got=%h exp=00", drop_s);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (ready_s !== 1'b1) begin
            bad++; $display("FAIL rel_ready got=%b exp=1", ready_s);
        end
    endtask

    task automatic test_latency();
        int k = 0;
        bit seen = 0;
        logic busy_ready = 1'b1;
        logic [63:0] got;
        q_s.delete();
        q_u.delete();
        data = 16'h7FFF;
        valid = 1'b1;
        while (!seen && k < 40) begin
            step();
            k++;
            if (k == 1) begin
                valid = 1'b0;
                busy_ready = ready_s;
            end
            if (start_s) seen = 1;
        end
        total++;
        if (busy_ready !== 1'b0) begin
            bad++; $display("FAIL conv_ready got=%b exp=0", busy_ready);
        end
        total++;
        if (k != 18) begin
            bad++; $display("FAIL latency got=%0d exp=18", k);
        end
        wait_bytes(8, 100);
        got = pop_line(0, 8);
        total++;
        if (got !== {"+32767", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_7fff got=%h", got);
        end
        step();
        total++;
        if (ready_s !== 1'b1) begin
            bad++; $display("FAIL idle_ready got=%b exp=1", ready_s);
        end
    endtask

    task automatic test_min();
        logic [63:0] got;
        q_s.delete();
        q_u.delete();
        send_sample(16'h8000);
        wait_bytes(8, 100);
        step();
        got = pop_line(0, 8);
        total++;
        if (got !== {"-32768", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_8000_s got=%h", got);
        end
        got = pop_line(1, 8);
        total++;
        if (got !== {"+32768", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_8000_u got=%h", got);
        end
    endtask

    task automatic test_zero_ffff();
        logic [63:0] got;
        q_s.delete();
        q_u.delete();
        send_sample(16'h0000);
        wait_bytes(8, 100);
        step();
        got = pop_line(0, 8);
        total++;
        if (got !== {"+00000", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_0000 got=%h", got);
        end
        q_u.delete();
        send_sample(16'hFFFF);
        wait_bytes(8, 100);
        step();
        got = pop_line(0, 8);
        total++;
        if (got !== {"-00001", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_ffff_s got=%h", got);
        end
        got = pop_line(1, 8);
        total++;
        if (got !== {"+65535", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_ffff_u got=%h", got);
        end
    endtask

    task automatic test_error();
        logic [63:0] got;
        q_s.delete();
        q_u.delete();
        data = 16'h1111;
        error = 1'b1;
        valid = 1'b1;
        step();
        valid = 1'b0;
        wait_bytes(3, 100);
        step();
        got = pop_line(0, 8);
        total++;
        if (got !== 64'h450D0A) begin
            bad++; $display("FAIL err_line got=%h exp=450d0a", got);
        end
        total++;
        if (drop_s !== 8'h00) begin
            bad++; $display("FAIL err_drop got=%h exp=00", drop_s);
        end
        repeat (50) step();
        total++;
        if (q_s.size() != 0) begin
            bad++; $display("FAIL err_repeat got=%0d exp=0", q_s.size());
        end
        total++;
        if (ready_s !== 1'b1) begin
            bad++; $display("FAIL err_ready got=%b exp=1", ready_s);
        end
        error = 1'b0;
        step();
        error = 1'b1;
        wait_bytes(3, 100);
        step();
        got = pop_line(0, 8);
        total++;
        if (got !== 64'h450D0A) begin
            bad++; $display("FAIL err_line2 got=%h exp=450d0a", got);
        end
        error = 1'b0;
        step();
    endtask

    task automatic test_busy_drops();
        logic [63:0] got;
        int k = 0;
        q_s.delete();
        q_u.delete();
        viol = 0;
        busy_len = 1000;
        send_sample(16'h1234);
        wait_bytes(1, 100);
        for (int i = 0; i < 10; i++) begin
            data = 16'(i);
            valid = 1'b1;
            step();
            valid = 1'b0;
            step();
        end
        total++;
        if (drop_s !== 8'd10) begin
            bad++; $display("FAIL drop_10 got=%0d exp=10", drop_s);
        end
        for (int i = 0; i < 290; i++) begin
            data = 16'hA5A5;
            valid = 1'b1;
            step();
            valid = 1'b0;
            step();
        end
        total++;
        if (drop_s !== 8'd255) begin
            bad++; $display("FAIL drop_sat got=%0d exp=255", drop_s);
        end
        wait_bytes(8, 12000);
        got = pop_line(0, 8);
        total++;
        if (got !== {"+04660", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_busy got=%h", got);
        end
        total++;
        if (viol != 0) begin
            bad++; $display("FAIL busy_pulse got=%0d exp=0", viol);
        end
        busy_len = 0;
        while (busy && k < 1200) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        q_s.delete();
        q_u.delete();
        send_sample(16'h5678);
        wait_bytes(3, 100);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (drop_s !== 8'h00) begin
            bad++; $display("FAIL mid_drop got=%0d exp=0", drop_s);
        end
        total++;
        if (txd_s !== 8'h00) begin
            bad++; $display("FAIL mid_txdata got=%h exp=00", txd_s);
        end
        step();
        total++;
        if (ready_s !== 1'b1) begin
            bad++; $display("FAIL mid_ready got=%b exp=1", ready_s);
        end
        repeat (40) step();
        total++;
        if (q_s.size() != 3) begin
            bad++; $display("FAIL mid_pulses got=%0d exp=3", q_s.size());
        end
        q_s.delete();
        q_u.delete();
        send_sample(16'h0001);
        wait_bytes(8, 100);
        step();
        got = pop_line(0, 8);
        total++;
        if (got !== {"+00001", 8'h0D, 8'h0A}) begin
            bad++; $display("FAIL line_0001 got=%h", got);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_min();
        test_zero_ffff();
        test_error();
        test_busy_drops();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
